// File: rtl/gcd_pkg.sv
// Shared types for the subtract-based GCD controller.
// State encoding is 3-bit binary.
package gcd_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CMP  = 3'd2,
    S_DONE = 3'd3,
    S_FAIL = 3'd4
  } state_t;

endpackage

// File: rtl/gcd_controller.sv
// Control FSM for the subtract-based GCD datapath: operand load,
// compare/subtract loop, result commit, iteration bound and abort.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int MAX_ITER = 1024,
  parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              a_eq_b,
  input  logic              a_gt_b,
  output logic              sel_A,
  output logic              sel_B,
  output logic              wr_A,
  output logic              wr_B,
  output logic              wr_res,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

  state_t state;
  state_t state_nxt;

  logic iter_clr;
  logic iter_inc;
  logic err_set;
  logic err_clr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      iter_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (iter_clr)      iter_cnt <= '0;
      else if (iter_inc) iter_cnt <= iter_cnt + 1'b1;
      if (err_clr)       err <= 1'b0;
      else if (err_set)  err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    wr_A      = 1'b0;
    wr_B      = 1'b0;
    wr_res    = 1'b0;
    iter_clr  = 1'b0;
    iter_inc  = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
          iter_clr  = 1'b1;
          err_clr   = 1'b1;
        end
      end
      S_LOAD: begin
        wr_A      = 1'b1;
        wr_B      = 1'b1;
        state_nxt = S_CMP;
      end
      S_CMP: begin
        if (a_eq_b) begin
          wr_res    = 1'b1;
          state_nxt = S_DONE;
        end else if (iter_cnt == ITER_MAX) begin
          // err rises on entry so it is visible while in FAIL
          err_set   = 1'b1;
          state_nxt = S_FAIL;
        end else if (a_gt_b) begin
          wr_A     = 1'b1;
          sel_A    = 1'b1;
          iter_inc = 1'b1;
        end else begin
          wr_B     = 1'b1;
          sel_B    = 1'b1;
          iter_inc = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_FAIL:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // abort overrides everything; in IDLE it only blocks the start
    if (abort) begin
      state_nxt = S_IDLE;
      sel_A     = 1'b0;
      sel_B     = 1'b0;
      wr_A      = 1'b0;
      wr_B      = 1'b0;
      wr_res    = 1'b0;
      iter_clr  = 1'b0;
      iter_inc  = 1'b0;
      err_set   = 1'b0;
      err_clr   = 1'b0;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_gcd_controller.sv
// Directed bench for gcd_controller with a behavioural
// subtract-GCD datapath model attached to its strobes.
module tb_gcd_controller;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic       abort;
  logic       a_eq_b;
  logic       a_gt_b;
  logic       sel_A;
  logic       sel_B;
  logic       wr_A;
  logic       wr_B;
  logic       wr_res;
  logic       busy;
  logic       done;
  logic       err;
  logic [4:0] iter_cnt;

  gcd_controller #(
    .MAX_ITER(16),
    .ITER_W  (5)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .abort   (abort),
    .a_eq_b  (a_eq_b),
    .a_gt_b  (a_gt_b),
    .sel_A   (sel_A),
    .sel_B   (sel_B),
    .wr_A    (wr_A),
    .wr_B    (wr_B),
    .wr_res  (wr_res),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] ra   = '0;
  logic [15:0] rb   = '0;
  logic [15:0] rres = '0;
  logic [15:0] da   = '0;
  logic [15:0] db   = '0;

  assign a_eq_b = (ra == rb);
  assign a_gt_b = (ra > rb);

  always @(posedge clk) begin
    if (wr_A)   ra   <= sel_A ? ra - rb : da;
    if (wr_B)   rb   <= sel_B ? rb - ra : db;
    if (wr_res) rres <= ra;
  end

  int n_tests = 0;
  int n_fail  = 0;

  int wra_n, wrb_n, res_n, done_n, both_n;
  int wra_c, wrb_c, res_c, done_c;
  bit busy_log [64];
  bit err_log  [64];
  bit strb_log [64];

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // starts at a negedge; cycle 0 is the cycle start is presented
  task automatic run(input int a, input int b, input int ncyc,
                     input int hold, input int abort_at);
    da = a[15:0];
    db = b[15:0];
    wra_n = 0; wrb_n = 0; res_n = 0; done_n = 0; both_n = 0;
    wra_c = -1; wrb_c = -1; res_c = -1; done_c = -1;
    for (int c = 0; c < ncyc; c++) begin
      start = (c <= hold);
      abort = (c == abort_at);
      #1;
      busy_log[c] = busy;
      err_log[c]  = err;
      strb_log[c] = wr_A | wr_B | wr_res | sel_A | sel_B;
      if (wr_A && sel_A) begin
        wra_n++;
        if (wra_c < 0) wra_c = c;
      end
      if (wr_B && sel_B) begin
        wrb_n++;
        if (wrb_c < 0) wrb_c = c;
      end
      if (wr_res) begin
        res_n++;
        if (res_c < 0) res_c = c;
      end
      if (done) begin
        done_n++;
        if (done_c < 0) done_c = c;
      end
      if (wr_A && wr_B && (sel_A || sel_B)) both_n++;
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("rst_outs", int'({busy, done, err, wr_A, wr_B, sel_A, sel_B, wr_res}), 0);
    chk("rst_iter", int'(iter_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    run(12, 8, 10, 0, -1);
    chk("g12_wra_cyc", wra_c, 2);
    chk("g12_wrb_cyc", wrb_c, 3);
    chk("g12_res_cyc", res_c, 4);
    chk("g12_done_cyc", done_c, 5);
    chk("g12_done_n", done_n, 1);
    chk("g12_res", int'(rres), 4);
    chk("g12_iter", int'(iter_cnt), 2);
    chk("g12_err", int'(err), 0);
    chk("g12_both", both_n, 0);
    chk("g12_busy_c1", int'(busy_log[1]), 1);
    chk("g12_busy_c0", int'(busy_log[0]), 0);

    run(7, 7, 8, 0, -1);
    chk("eq_subs", wra_n + wrb_n, 0);
    chk("eq_done_cyc", done_c, 3);
    chk("eq_res", int'(rres), 7);
    chk("eq_iter", int'(iter_cnt), 0);

    run(0, 5, 25, 0, -1);
    chk("z_wrb_n", wrb_n, 16);
    chk("z_wra_n", wra_n, 0);
    chk("z_done_n", done_n, 0);
    chk("z_res_n", res_n, 0);
    chk("z_err_c18", int'(err_log[18]), 0);
    chk("z_err_c19", int'(err_log[19]), 1);
    chk("z_busy_c19", int'(busy_log[19]), 1);
    chk("z_busy_c20", int'(busy_log[20]), 0);
    chk("z_err_end", int'(err_log[24]), 1);
    chk("z_iter", int'(iter_cnt), 16);

    run(9, 6, 10, 0, -1);
    chk("r_err_c0", int'(err_log[0]), 1);
    chk("r_err_c1", int'(err_log[1]), 0);
    chk("r_done_cyc", done_c, 5);
    chk("r_res", int'(rres), 3);
    chk("r_err_end", int'(err), 0);

    run(1000, 1, 20, 0, 10);
    chk("ab_busy_c9", int'(busy_log[9]), 1);
    chk("ab_strb_c10", int'(strb_log[10]), 0);
    chk("ab_busy_c11", int'(busy_log[11]), 0);
    chk("ab_res_n", res_n, 0);
    chk("ab_done_n", done_n, 0);
    chk("ab_iter", int'(iter_cnt), 8);
    chk("ab_err", int'(err), 0);

    run(21, 14, 16, 5, -1);
    chk("hold_done_n", done_n, 1);
    chk("hold_done_cyc", done_c, 5);
    chk("hold_res", int'(rres), 7);
    chk("hold_busy_c6", int'(busy_log[6]), 0);
    chk("hold_busy_c15", int'(busy_log[15]), 0);

    run(1000, 1, 6, 0, -1);
    chk("mr_busy_pre", int'(busy), 1);
    chk("mr_res_n", res_n, 0);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mr_outs", int'({busy, done, err, wr_A, wr_B, sel_A, sel_B, wr_res}), 0);
    chk("mr_iter", int'(iter_cnt), 0);
    @(negedge clk);
    chk("mr_busy_hold", int'(busy), 0);
    n_rst = 1'b1;
    @(negedge clk);

    run(48, 18, 12, 0, -1);
    chk("post_done_cyc", done_c, 7);
    chk("post_res", int'(rres), 6);
    chk("post_iter", int'(iter_cnt), 4);
    chk("post_res_n", res_n, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
Control FSM that sequences the subtract-based GCD datapath: loads operands, steers the compare/subtract loop from the a_eq_b / a_gt_b status flags, and commits the result. It exposes a start/busy/done handshake to the host, a bounded iteration count with error reporting, and a synchronous abort. It is instantiated next to the GCD datapath in gcd_top; its strobes connect one-to-one to the datapath's sel/wr inputs.

Parameters:
MAX_ITER, 1024, max subtract steps per operation before declaring failure (must be >= 1)
ITER_W, $clog2(MAX_ITER+1), width of the iteration counter and iter_cnt output

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
start  input  1  request new GCD; sampled only in IDLE
abort  input  1  cancel the current operation; takes priority over everything except reset
a_eq_b  input  1  datapath status, A == B
a_gt_b  input  1  datapath status, A > B
sel_A  output  1  0: load A_in, 1: A <= A - B
sel_B  output  1  0: load B_in, 1: B <= B - A
wr_A  output  1  A register write enable
wr_B  output  1  B register write enable
wr_res  output  1  result register write enable
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; result valid on datapath res
err  output  1  sticky failure flag, held until next accepted start
iter_cnt  output  ITER_W  subtract steps taken in current/last operation

Behaviour:
- Reset (async, n_rst low): state IDLE, iter_cnt 0, err 0; all strobes, busy and done 0. Reset mid-operation abandons it; no wr_res is issued.
- States: IDLE, LOAD, CMP, DONE, FAIL; encoding 3 bits, binary.
- IDLE: all strobes 0. start=1 and abort=0 -> LOAD; clear iter_cnt and err on that edge.
- LOAD: wr_A=wr_B=1, sel_A=sel_B=0 (operands captured). -> CMP.
- CMP (Mealy strobes, evaluated in priority order):
  - a_eq_b=1: wr_res=1 -> DONE.
  - else iter_cnt == MAX_ITER: no writes -> FAIL.
  - else a_gt_b=1: wr_A=1, sel_A=1; iter_cnt+1; stay in CMP.
  - else: wr_B=1, sel_B=1; iter_cnt+1; stay in CMP.
  - Never assert wr_A and wr_B together in CMP.
- DONE: done=1 for exactly one cycle -> IDLE. A start asserted during DONE is ignored.
- FAIL: err set to 1 -> IDLE. done is not asserted. err stays high until the next accepted start.
- abort=1 in LOAD/CMP/DONE/FAIL: all strobes forced 0 this cycle; next state IDLE; iter_cnt holds its value; err unchanged; no done.
- start while busy: ignored, no queuing.
- Latency: with k subtract steps, done is high in cycle k+3 after the cycle in which start is sampled (start cycle = 0).
- Equal operands (k=0): done in cycle 3.
- Zero operand (e.g. A=0, B=5): the loop never converges. It is terminated via MAX_ITER -> FAIL, with iter_cnt = MAX_ITER.
- iter_cnt never wraps; the counter stops at MAX_ITER.
- busy = (state != IDLE). done = (state == DONE). Both are decoded from the state register, so they are glitch-free.

Decomposition:
- gcd_pkg: state localparams (IDLE, LOAD, CMP, DONE, FAIL) and the state width constant.
- No sub-module. The iteration counter stays inline (a few lines).
- gcd_top wiring of controller plus datapath is a separate integration file; it is not part of this block.

Test Plan:
- Operands 12, 8; start pulse in cycle 0 -> wr_A(sub) in cycle 2, wr_B(sub) in cycle 3, wr_res in cycle 4, done in cycle 5, res=4, iter_cnt=2, err=0.
- Operands 7, 7 -> no subtract strobes; done in cycle 3; res=7; iter_cnt=0.
- MAX_ITER=16, operands 0, 5 -> 16 wr_B strobes, then FAIL; err=1 from cycle 19 onward; done never pulses; busy low afterwards. A new start with 9, 6 clears err; result res=3.
- Operands 1000, 1; abort asserted in cycle 10 -> no strobes in cycle 10; IDLE at cycle 11; wr_res never asserted; iter_cnt=8 held.
- start held high during an operation of 21, 14 -> exactly one operation; done pulses once (res=7); a second operation begins only if start is still high in IDLE after DONE.
- n_rst pulsed low mid-CMP -> outputs 0 immediately; state IDLE; no wr_res; a subsequent start of 48, 18 gives res=6.
